// File: rtl/display_scan.sv
// Binary-to-BCD display driver: a double-dabble engine fills the digit latches,
// and a free-running scanner multiplexes them onto one BCD bus.
module display_scan #(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  value,
  input  logic              load,
  input  logic              blank_zeros,
  output logic              busy,
  output logic              overflow,
  output logic [3:0]        data,
  output logic [DIGITS-1:0] digit_en
);

  localparam int NIB   = DIGITS + 1;
  localparam int BCD_W = 4 * NIB;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MAX_VAL = 32'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic [3:0]          lat_q [DIGITS];
  logic [3:0]          lat_d [DIGITS];
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic [3:0]          data_q, data_d;

  logic [BCD_W-1:0]    bcd_adj_s;
  logic [3:0]          nib_s;
  logic                lead_s;

  // Next-state logic for the conversion FSM and the display scanner
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    lat_d      = lat_q;
    bcd_adj_s  = bcd_q;
    nib_s      = 4'h0;
    lead_s     = 1'b1;

    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d      = value;
          bcd_d      = {BCD_W{1'b0}};
          cnt_d      = CNT_W'(BIN_W);
          // Overflow is judged on the captured value, independent of BCD width.
          ovf_pend_d = (32'(value) > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end else begin
          state_d    = IDLE;
        end
      end
      SHIFT: begin
        for (int i = 0; i < NIB; i++) begin
          nib_s = bcd_q[4*i +: 4];
          if (nib_s >= 4'd5) begin
            bcd_adj_s[4*i +: 4] = nib_s + 4'd3;
          end else begin
            bcd_adj_s[4*i +: 4] = nib_s;
          end
        end
        bcd_d = {bcd_adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        overflow_d = ovf_pend_q;
        busy_d     = 1'b0;
        state_d    = IDLE;
        // Walk from the top digit down; blanking stops at the first nonzero nibble.
        for (int i = DIGITS - 1; i >= 0; i--) begin
          nib_s = bcd_q[4*i +: 4];
          if (ovf_pend_q) begin
            lat_d[i] = 4'hF;
          end else if (blank_zeros && lead_s && (nib_s == 4'h0) && (i != 0)) begin
            lat_d[i] = 4'hF;
          end else begin
            lat_d[i] = nib_s;
            lead_s   = 1'b0;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d = {PRE_W{1'b0}};
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
      idx_d = idx_q;
    end
    digit_en_d = DIGITS'(1) << idx_d;
    data_d     = lat_q[idx_d];
  end

  // State registers; reset blanks the display and aborts any conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= {BIN_W{1'b0}};
      bcd_q      <= {BCD_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        lat_q[i] <= 4'hF;
      end
      pre_q      <= {PRE_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      digit_en_q <= DIGITS'(1);
      data_q     <= 4'hF;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      lat_q      <= lat_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      digit_en_q <= digit_en_d;
      data_q     <= data_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign data     = data_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with a short refresh period so every digit is
// visited within a few cycles.
module tb_display_scan;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int RDIV   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BIN_W-1:0]  value = 14'd0;
  logic              load = 1'b0;
  logic              blank_zeros = 1'b0;
  logic              busy;
  logic              overflow;
  logic [3:0]        data;
  logic [DIGITS-1:0] digit_en;

  int n_cmp = 0;
  int n_err = 0;

  display_scan #(.DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .blank_zeros(blank_zeros), .busy(busy), .overflow(overflow),
    .data(data), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the load edge.
  task automatic pulse_load(input logic [BIN_W-1:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // exp holds the expected digits as hex nibbles, nibble 0 = least significant digit.
  task automatic check_digits(input string tag, input logic [15:0] exp);
    int t;
    logic [3:0] want_en;
    repeat (2) @(negedge clk);
    for (int k = 0; k < DIGITS; k++) begin
      want_en = 4'b0001 << k;
      t = 0;
      while (digit_en !== want_en && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("%s_en%0d", tag, k), {28'd0, digit_en}, {28'd0, want_en});
      chk($sformatf("%s_d%0d", tag, k), {28'd0, data}, {28'd0, exp[4*k +: 4]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values and scan stepping
    #12;
    chk("rst_data", {28'd0, data}, 32'hF);
    chk("rst_en", {28'd0, digit_en}, 32'h1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("scan_hold", {28'd0, digit_en}, 32'h1);
    @(negedge clk);
    chk("scan_1", {28'd0, digit_en}, 32'h2);
    repeat (RDIV) @(negedge clk);
    chk("scan_2", {28'd0, digit_en}, 32'h4);
    repeat (RDIV) @(negedge clk);
    chk("scan_3", {28'd0, digit_en}, 32'h8);
    repeat (RDIV) @(negedge clk);
    chk("scan_wrap", {28'd0, digit_en}, 32'h1);
    chk("scan_blank", {28'd0, data}, 32'hF);

    // 2: 1234 without blanking; busy lasts BIN_W+1 cycles
    blank_zeros = 1'b0;
    pulse_load(14'd1234);
    for (int i = 0; i < BIN_W + 1; i++) begin
      chk($sformatf("busy_hi%0d", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("ovf_1234", {31'd0, overflow}, 32'd0);
    check_digits("v1234", 16'h1234);

    // 3: leading-zero blanking
    blank_zeros = 1'b1;
    pulse_load(14'd7);
    wait_idle("v7");
    check_digits("v7bz", 16'hFFF7);
    pulse_load(14'd0);
    wait_idle("v0");
    check_digits("v0bz", 16'hFFF0);
    pulse_load(14'd10);
    wait_idle("v10");
    check_digits("v10bz", 16'hFF10);
    pulse_load(14'd1000);
    wait_idle("v1000");
    check_digits("v1000bz", 16'h1000);
    blank_zeros = 1'b0;
    pulse_load(14'd0);
    wait_idle("v0nb");
    check_digits("v0nb", 16'h0000);

    // 4: overflow boundary
    pulse_load(14'd10000);
    wait_idle("v10000");
    chk("ovf_10000", {31'd0, overflow}, 32'd1);
    check_digits("v10000", 16'hFFFF);
    pulse_load(14'd9999);
    wait_idle("v9999");
    chk("ovf_9999", {31'd0, overflow}, 32'd0);
    check_digits("v9999", 16'h9999);

    // 5: load during SHIFT is ignored
    pulse_load(14'd1234);
    chk("busy_e0", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    value = 14'd5678;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    for (int i = 3; i < BIN_W + 1; i++) begin
      chk($sformatf("ign_busy%0d", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    chk("ign_fall", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("ign_norestart", {31'd0, busy}, 32'd0);
    check_digits("ign1234", 16'h1234);

    // 6: asynchronous reset during a conversion
    pulse_load(14'd4321);
    wait_idle("v4321");
    check_digits("v4321", 16'h4321);
    pulse_load(14'd1111);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", {28'd0, data}, 32'hF);
    chk("arst_en", {28'd0, digit_en}, 32'h1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_digits("post_rst", 16'hFFFF);
    pulse_load(14'd42);
    wait_idle("v42");
    check_digits("v42", 16'h0042);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
